// File: rtl/score_bcd_converter_pkg.sv
// Shared display constants: FSM state encoding and conversion defaults.
package score_bcd_converter_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam int MAX_SCORE_DEF  = 999;
  localparam int SHIFT_BITS_DEF = 10;
  localparam int BCD_W          = 12;

endpackage

// File: rtl/score_bcd_converter_if.sv
// Request/result bundle between the score source and the BCD converter.
interface score_bcd_converter_if #(
  parameter int SCORE_WIDTH = 32
);

  logic [SCORE_WIDTH-1:0] score;
  logic                   start;
  logic                   busy;
  logic                   done;
  logic [3:0]             hundreds;
  logic [3:0]             tens;
  logic [3:0]             ones;
  logic                   overflow;

  modport master (
    output score, start,
    input  busy, done, hundreds, tens, ones, overflow
  );

  modport slave (
    input  score, start,
    output busy, done, hundreds, tens, ones, overflow
  );

endinterface

// File: rtl/score_bcd_converter_bcd_add3.sv
// Double-dabble nibble adjust: add 3 to any BCD nibble of 5 or more.
module bcd_add3 (
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);

  // Pre-shift correction so the nibble carries correctly after doubling
  always_comb begin
    o_nib = i_nib;
    if (i_nib >= 4'd5) begin
      o_nib = i_nib + 4'd3;
    end
  end

endmodule

// File: rtl/score_bcd_converter.sv
// Sequential binary-to-BCD score converter (shift-and-add-3), saturating at MAX_SCORE.
module score_bcd_converter
  import score_bcd_converter_pkg::*;
#(
  parameter int SCORE_WIDTH = 32,
  parameter int MAX_SCORE   = MAX_SCORE_DEF,
  parameter int SHIFT_BITS  = SHIFT_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  resetn,
  score_bcd_converter_if.slave  bus
);

  localparam int SR_W  = BCD_W + SHIFT_BITS;
  localparam int CNT_W = $clog2(SHIFT_BITS + 1);
  localparam logic [SCORE_WIDTH-1:0] MAX_S = SCORE_WIDTH'(MAX_SCORE);

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic [CNT_W-1:0] r_cnt;
  logic [SR_W-1:0]  r_shift;
  logic [SR_W-1:0]  w_adjusted;
  logic [BCD_W-1:0] w_bcd_adj;
  logic             r_sat;
  logic [3:0]       r_hundreds;
  logic [3:0]       r_tens;
  logic [3:0]       r_ones;
  logic             r_overflow;
  logic             r_done;

  bcd_add3 u_add3_ones (
    .i_nib (r_shift[SHIFT_BITS+3 -: 4]),
    .o_nib (w_bcd_adj[3:0])
  );

  bcd_add3 u_add3_tens (
    .i_nib (r_shift[SHIFT_BITS+7 -: 4]),
    .o_nib (w_bcd_adj[7:4])
  );

  bcd_add3 u_add3_hundreds (
    .i_nib (r_shift[SHIFT_BITS+11 -: 4]),
    .o_nib (w_bcd_adj[11:8])
  );

  assign w_adjusted = {w_bcd_adj, r_shift[SHIFT_BITS-1:0]};

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; start only matters in IDLE
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          w_next   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_cnt == CNT_W'(SHIFT_BITS - 1)) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Conversion datapath: capture on accept, adjust-and-shift while in SHIFT
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_sat   <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_shift <= {{BCD_W{1'b0}}, bus.score[SHIFT_BITS-1:0]};
      r_sat   <= (bus.score > MAX_S);
    end else if (r_state == S_SHIFT) begin
      r_cnt   <= r_cnt + CNT_W'(1);
      r_shift <= w_adjusted << 1;
    end
  end

  // Result registers: only the DONE state updates the visible digits
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_done     <= 1'b0;
      r_hundreds <= '0;
      r_tens     <= '0;
      r_ones     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= (r_state == S_DONE);
      if (r_state == S_DONE) begin
        r_overflow <= r_sat;
        if (r_sat) begin
          r_hundreds <= 4'd9;
          r_tens     <= 4'd9;
          r_ones     <= 4'd9;
        end else begin
          r_hundreds <= r_shift[SR_W-1 -: 4];
          r_tens     <= r_shift[SR_W-5 -: 4];
          r_ones     <= r_shift[SHIFT_BITS+3 -: 4];
        end
      end
    end
  end

  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = r_done;
  assign bus.hundreds = r_hundreds;
  assign bus.tens     = r_tens;
  assign bus.ones     = r_ones;
  assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_score_bcd_converter.sv
// Self-checking bench for score_bcd_converter: timeline model plus directed and random stimulus.
module tb_score_bcd_converter;

  localparam int SB  = 10;
  localparam int LAT = SB + 1;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  score_bcd_converter_if #(.SCORE_WIDTH(32)) bus ();

  score_bcd_converter #(
    .SCORE_WIDTH (32),
    .MAX_SCORE   (999),
    .SHIFT_BITS  (SB)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Reference model: a request is accepted when idle, the result appears LAT edges later.
  int          m_phase = 0;
  logic [31:0] m_val   = '0;
  bit          m_done  = 1'b0;
  int          m_h     = 0;
  int          m_t     = 0;
  int          m_o     = 0;
  bit          m_ovf   = 1'b0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_phase <= 0;
      m_done  <= 1'b0;
      m_h     <= 0;
      m_t     <= 0;
      m_o     <= 0;
      m_ovf   <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_phase == 0) begin
        if (bus.start) begin
          m_val   <= bus.score;
          m_phase <= 1;
        end
      end else if (m_phase == LAT) begin
        m_done  <= 1'b1;
        m_phase <= 0;
        if (m_val > 32'd999) begin
          m_h   <= 9;
          m_t   <= 9;
          m_o   <= 9;
          m_ovf <= 1'b1;
        end else begin
          m_h   <= int'(m_val / 100);
          m_t   <= int'((m_val / 10) % 10);
          m_o   <= int'(m_val % 10);
          m_ovf <= 1'b0;
        end
      end else begin
        m_phase <= m_phase + 1;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",     int'(bus.busy),     int'(m_phase != 0));
      check("done",     int'(bus.done),     int'(m_done));
      check("hundreds", int'(bus.hundreds), m_h);
      check("tens",     int'(bus.tens),     m_t);
      check("ones",     int'(bus.ones),     m_o);
      check("overflow", int'(bus.overflow), int'(m_ovf));
    end
  end

  // One conversion with literal expectations; optional disturbance mid-flight
  task automatic run_one(input logic [31:0] val, input int eh, input int et, input int eo,
                         input bit eovf, input bit disturb);
    int k;
    int bcnt;
    bus.score = val;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    k    = 0;
    bcnt = 0;
    while (!bus.done && k < 40) begin
      if (bus.busy) bcnt++;
      if (disturb && k == 3) begin
        bus.score = 32'd301;
        bus.start = 1'b1;
      end
      if (disturb && k == 4) bus.start = 1'b0;
      @(negedge clk);
      k++;
    end
    check("latency",       k,                  LAT);
    check("busy_cycles",   bcnt,               LAT);
    check("lit_hundreds",  int'(bus.hundreds), eh);
    check("lit_tens",      int'(bus.tens),     et);
    check("lit_ones",      int'(bus.ones),     eo);
    check("lit_overflow",  int'(bus.overflow), int'(eovf));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    int prev;
    bus.score = '0;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy",     int'(bus.busy),     0);
    check("rst_done",     int'(bus.done),     0);
    check("rst_digits",   int'({bus.hundreds, bus.tens, bus.ones}), 0);
    check("rst_overflow", int'(bus.overflow), 0);
    chk_en = 1'b1;

    // Start on the first edge after reset release
    resetn = 1'b1;
    run_one(32'd0,    0, 0, 0, 1'b0, 1'b0);
    run_one(32'd472,  4, 7, 2, 1'b0, 1'b0);
    run_one(32'd999,  9, 9, 9, 1'b0, 1'b0);
    run_one(32'd1000, 9, 9, 9, 1'b1, 1'b0);
    run_one(32'd58,   0, 5, 8, 1'b0, 1'b1);
    ndone = 0;
    repeat (14) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check("single_done", ndone, 0);

    // Reset during SHIFT aborts the conversion
    bus.score = 32'd500;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("abort_busy",     int'(bus.busy),     0);
    check("abort_done",     int'(bus.done),     0);
    check("abort_hundreds", int'(bus.hundreds), 0);
    check("abort_tens",     int'(bus.tens),     0);
    check("abort_ones",     int'(bus.ones),     0);
    check("abort_overflow", int'(bus.overflow), 0);
    ndone = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    resetn = 1'b1;
    run_one(32'd10, 0, 1, 0, 1'b0, 1'b0);

    // start held high: back-to-back conversions every LAT+1 cycles
    bus.score = 32'd123;
    bus.start = 1'b1;
    ndone = 0;
    prev  = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.done) begin
        if (prev >= 0) check("period", i - prev, LAT + 1);
        check("held_digits", int'({bus.hundreds, bus.tens, bus.ones}), int'(12'h123));
        prev = i;
        ndone++;
      end
    end
    check("held_done_count", ndone, 5);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);

    // Random traffic, including start toggling while busy and score changes in flight
    repeat (600) begin
      @(negedge clk);
      bus.start = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0: bus.score = $urandom_range(0, 999);
        1: bus.score = $urandom_range(990, 1010);
        2: bus.score = $urandom();
        default: ;
      endcase
    end
    bus.start = 1'b0;
    repeat (15) @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
